// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared state encodings, wait-limit default and hazard-priority ordering for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  localparam int unsigned MEM_WAIT_MAX_DEFAULT = 15;
  localparam int unsigned WAIT_CNT_BITS        = 8;

  // Resolved action for one cycle. HZ_MEM doubles as "freeze everything".
  typedef enum logic [1:0] {
    HZ_NONE   = 2'd0,
    HZ_LU     = 2'd1,
    HZ_BRANCH = 2'd2,
    HZ_MEM    = 2'd3
  } hazard_e;

  function automatic hazard_e resolve_hazard(input logic mem_stall, input logic branch, input logic lu);
    if (mem_stall)   return HZ_MEM;
    else if (branch) return HZ_BRANCH;
    else if (lu)     return HZ_LU;
    else             return HZ_NONE;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the datapath and enable/flush outputs back to the pipeline register groups.
interface pipeline_hazard_ctrl_if #(parameter int unsigned RegAddrBits = 5);
  logic                   Tick;
  logic [RegAddrBits-1:0] ID_Rs1;
  logic [RegAddrBits-1:0] ID_Rs2;
  logic                   ID_UsesRs1;
  logic                   ID_UsesRs2;
  logic                   EX_MemRead;
  logic [RegAddrBits-1:0] EX_Rd;
  logic                   EX_BranchTaken;
  logic                   MEM_Req;
  logic                   MEM_Ready;
  logic                   PC_En;
  logic                   IFID_En;
  logic                   IDEX_En;
  logic                   EXMEM_En;
  logic                   MEMWB_En;
  logic                   IFID_Flush;
  logic                   IDEX_Flush;
  logic                   EXMEM_Flush;
  logic                   MemTimeout;
  logic [1:0]             State;

  modport master (
    output Tick, ID_Rs1, ID_Rs2, ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_Rd,
           EX_BranchTaken, MEM_Req, MEM_Ready,
    input  PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En,
           IFID_Flush, IDEX_Flush, EXMEM_Flush, MemTimeout, State
  );

  modport slave (
    input  Tick, ID_Rs1, ID_Rs2, ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_Rd,
           EX_BranchTaken, MEM_Req, MEM_Ready,
    output PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En,
           IFID_Flush, IDEX_Flush, EXMEM_Flush, MemTimeout, State
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect_unit.sv
// Combinational load-use comparator: flags an ID source that matches the non-zero destination of a load in EX.
module hazard_detect_unit #(
  parameter int unsigned RegAddrBits = 5
) (
  input  logic [RegAddrBits-1:0] id_rs1_i,
  input  logic [RegAddrBits-1:0] id_rs2_i,
  input  logic                   id_uses_rs1_i,
  input  logic                   id_uses_rs2_i,
  input  logic                   ex_mem_read_i,
  input  logic [RegAddrBits-1:0] ex_rd_i,
  output logic                   load_use_o
);
  assign load_use_o = ex_mem_read_i & (ex_rd_i != '0) &
                      ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
                       (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline enable/flush sequencer: zero-cycle combinational stalls, one-cycle state update, sticky memory timeout.
// HAZARD_PERF_CNT_EN adds saturating load-use, memory-stall and branch-flush counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned RegAddrBits = 5,
  parameter int unsigned MemWaitMax  = MEM_WAIT_MAX_DEFAULT
`ifdef HAZARD_PERF_CNT_EN
  , parameter int unsigned CntBits   = 16
`endif
) (
  input  logic                 Clock,
  input  logic                 Reset,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CntBits-1:0] LuStallCnt
  , output logic [CntBits-1:0] MemStallCnt
  , output logic [CntBits-1:0] FlushCnt
`endif
);

  localparam logic [WAIT_CNT_BITS-1:0] WAIT_LAST = WAIT_CNT_BITS'(MemWaitMax - 1);

  state_e                   state_q, state_d;
  logic [WAIT_CNT_BITS-1:0] wait_cnt_q, wait_cnt_d;
  logic                     timeout_q, timeout_d;
  logic                     load_use;
  logic                     mem_stall;
  hazard_e                  act;
  logic [4:0]               en;  // {PC, IFID, IDEX, EXMEM, MEMWB}
  logic [2:0]               fl;  // {IFID, IDEX, EXMEM}

  hazard_detect_unit #(.RegAddrBits(RegAddrBits)) u_hdu (
    .id_rs1_i      (hz.ID_Rs1),
    .id_rs2_i      (hz.ID_Rs2),
    .id_uses_rs1_i (hz.ID_UsesRs1),
    .id_uses_rs2_i (hz.ID_UsesRs2),
    .ex_mem_read_i (hz.EX_MemRead),
    .ex_rd_i       (hz.EX_Rd),
    .load_use_o    (load_use)
  );

  assign mem_stall = hz.MEM_Req & ~hz.MEM_Ready;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    act        = HZ_MEM;
    case (state_q)
      ST_RUN: begin
        act = resolve_hazard(mem_stall, hz.EX_BranchTaken, load_use);
        if (act == HZ_MEM) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_CNT_BITS'(1);
          if (WAIT_LAST == '0) begin
            state_d   = ST_ERR;
            timeout_d = 1'b1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (hz.MEM_Ready) begin
          // Frozen stages re-present on release, so branch/LU are judged again here.
          act        = resolve_hazard(1'b0, hz.EX_BranchTaken, load_use);
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_BITS'(1);
          if (wait_cnt_q >= WAIT_LAST) begin
            state_d   = ST_ERR;
            timeout_d = 1'b1;
          end
        end
      end
      ST_ERR: ;
      default: state_d = ST_ERR;
    endcase
  end

  always_comb begin
    en = '0;
    fl = '0;
    if (!Reset) begin
      fl = 3'b111;
    end else if (hz.Tick) begin
      case (act)
        HZ_MEM:    en = 5'b00000;
        HZ_BRANCH: begin en = 5'b11111; fl = 3'b110; end
        HZ_LU:     begin en = 5'b00111; fl = 3'b010; end
        default:   en = 5'b11111;
      endcase
    end
  end

  assign {hz.PC_En, hz.IFID_En, hz.IDEX_En, hz.EXMEM_En, hz.MEMWB_En} = en;
  assign {hz.IFID_Flush, hz.IDEX_Flush, hz.EXMEM_Flush}               = fl;
  assign hz.MemTimeout = timeout_q;
  assign hz.State      = state_q;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (hz.Tick) begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CntBits-1:0] lu_cnt_q, mem_cnt_q, fl_cnt_q;
  logic               live, lu_ev, mem_ev, br_ev;

  assign live   = Reset & hz.Tick & ((state_q == ST_RUN) | (state_q == ST_MEM_WAIT));
  assign lu_ev  = live & (act == HZ_LU);
  assign mem_ev = live & (act == HZ_MEM);
  assign br_ev  = live & (act == HZ_BRANCH);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      lu_cnt_q  <= '0;
      mem_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      if (lu_ev  && !(&lu_cnt_q))  lu_cnt_q  <= lu_cnt_q  + CntBits'(1);
      if (mem_ev && !(&mem_cnt_q)) mem_cnt_q <= mem_cnt_q + CntBits'(1);
      if (br_ev  && !(&fl_cnt_q))  fl_cnt_q  <= fl_cnt_q  + CntBits'(1);
    end
  end

  assign LuStallCnt  = lu_cnt_q;
  assign MemStallCnt = mem_cnt_q;
  assign FlushCnt    = fl_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: RUN-state vector table plus reset, wait, tick, timeout sequences.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  pipeline_hazard_ctrl_if #(.RegAddrBits(5)) hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] lu_cnt, mem_cnt, fl_cnt;
`endif

  pipeline_hazard_ctrl #(
    .RegAddrBits (5),
    .MemWaitMax  (15)
`ifdef HAZARD_PERF_CNT_EN
    , .CntBits   (16)
`endif
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .hz    (hz)
`ifdef HAZARD_PERF_CNT_EN
    , .LuStallCnt  (lu_cnt)
    , .MemStallCnt (mem_cnt)
    , .FlushCnt    (fl_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       rd;
    logic [4:0] ex_rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic       req;
    logic       rdy;
    logic       tick;
    logic [4:0] en;
    logic [2:0] fl;
  } vec_t;

  localparam int NV = 11;
  vec_t vec [NV];

  function automatic vec_t mk(input string n, input logic rd, input logic [4:0] ex_rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                              input logic u2, input logic br, input logic req, input logic rdy,
                              input logic tick, input logic [4:0] en, input logic [2:0] fl);
    vec_t v;
    v.name = n; v.rd = rd; v.ex_rd = ex_rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.br = br; v.req = req; v.rdy = rdy; v.tick = tick; v.en = en; v.fl = fl;
    return v;
  endfunction

  function automatic logic [4:0] en_vec();
    return {hz.PC_En, hz.IFID_En, hz.IDEX_En, hz.EXMEM_En, hz.MEMWB_En};
  endfunction

  function automatic logic [2:0] fl_vec();
    return {hz.IFID_Flush, hz.IDEX_Flush, hz.EXMEM_Flush};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [4:0] en_e, input logic [2:0] fl_e,
                         input logic [1:0] st_e);
    chk({nm, ".en"},    16'(en_vec()),  16'(en_e));
    chk({nm, ".flush"}, 16'(fl_vec()),  16'(fl_e));
    chk({nm, ".state"}, 16'(hz.State),  16'(st_e));
  endtask

  task automatic drive(input logic rd, input logic [4:0] ex_rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2, input logic br,
                       input logic req, input logic rdy, input logic tick);
    hz.EX_MemRead = rd; hz.EX_Rd = ex_rd; hz.ID_Rs1 = rs1; hz.ID_Rs2 = rs2;
    hz.ID_UsesRs1 = u1; hz.ID_UsesRs2 = u2; hz.EX_BranchTaken = br;
    hz.MEM_Req = req; hz.MEM_Ready = rdy; hz.Tick = tick;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0;
    idle();
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    //            name         rd ex_rd rs1  rs2  u1 u2 br req rdy tk  en        fl
    vec[0]  = mk("idle",       0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 5'b11111, 3'b000);
    vec[1]  = mk("lu_rs2",     1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0, 1, 5'b00111, 3'b010);
    vec[2]  = mk("lu_rs1",     1, 5'd7, 5'd7, 5'd3, 1, 0, 0, 0, 0, 1, 5'b00111, 3'b010);
    vec[3]  = mk("lu_rd0",     1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 1, 5'b11111, 3'b000);
    vec[4]  = mk("lu_unused",  1, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, 0, 1, 5'b11111, 3'b000);
    vec[5]  = mk("no_load",    0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, 1, 5'b11111, 3'b000);
    vec[6]  = mk("branch",     0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 1, 5'b11111, 3'b110);
    vec[7]  = mk("branch_lu",  1, 5'd5, 5'd0, 5'd5, 0, 1, 1, 0, 0, 1, 5'b11111, 3'b110);
    vec[8]  = mk("mem_hit",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 1, 5'b11111, 3'b000);
    vec[9]  = mk("tick0_lu",   1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0, 0, 5'b00000, 3'b000);
    vec[10] = mk("mem_hit_lu", 1, 5'd9, 5'd9, 5'd0, 1, 0, 0, 1, 1, 1, 5'b00111, 3'b010);

    // Reset held for two edges, then released.
    idle();
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    #1;
    chk_out("reset", 5'b00000, 3'b111, 2'd0);
    chk("reset.timeout", 16'(hz.MemTimeout), 16'd0);
    Reset = 1'b1;
    @(negedge Clock);
    #1;
    chk_out("reset_release", 5'b11111, 3'b000, 2'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge Clock);
      drive(vec[i].rd, vec[i].ex_rd, vec[i].rs1, vec[i].rs2, vec[i].u1, vec[i].u2,
            vec[i].br, vec[i].req, vec[i].rdy, vec[i].tick);
      #1;
      chk_out(vec[i].name, vec[i].en, vec[i].fl, 2'd0);
    end

    // Load-use lasts one cycle once the load leaves EX.
    @(negedge Clock);
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk_out("lu_cycle1", 5'b00111, 3'b010, 2'd0);
    @(negedge Clock);
    idle();
    #1;
    chk_out("lu_cycle2", 5'b11111, 3'b000, 2'd0);

    // Three-cycle memory wait, branch ignored while frozen, LU re-evaluated on release.
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    chk_out("mw_entry", 5'b00000, 3'b000, 2'd0);
    @(negedge Clock);
    #1;
    chk_out("mw_frozen", 5'b00000, 3'b000, 2'd1);
    @(negedge Clock);
    hz.EX_BranchTaken = 1'b1;
    #1;
    chk_out("mw_branch_ignored", 5'b00000, 3'b000, 2'd1);
    @(negedge Clock);
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk_out("mw_release_lu", 5'b00111, 3'b010, 2'd1);
    @(negedge Clock);
    idle();
    #1;
    chk_out("mw_back_run", 5'b11111, 3'b000, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf.mem_stall", mem_cnt, 16'd3);
    chk("perf.lu_stall",  lu_cnt,  16'd1);
    chk("perf.flush",     fl_cnt,  16'd0);
`endif

    // Tick=0 in MEM_WAIT with ready: nothing moves.
    @(negedge Clock);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge Clock);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    chk_out("tick0_wait", 5'b00000, 3'b000, 2'd1);
    @(negedge Clock);
    #1;
    chk_out("tick0_hold", 5'b00000, 3'b000, 2'd1);
    hz.Tick = 1'b1;
    #1;
    chk_out("tick1_release", 5'b11111, 3'b000, 2'd1);
    @(negedge Clock);
    idle();
    #1;
    chk_out("tick1_run", 5'b11111, 3'b000, 2'd0);

    // Reset in the middle of a memory stall.
    @(negedge Clock);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk_out("rst_mid_stall", 5'b00000, 3'b111, 2'd1);
    @(negedge Clock);
    #1;
    chk_out("rst_mid_stall_edge", 5'b00000, 3'b111, 2'd0);
    Reset = 1'b1;
    idle();
    #1;
    chk_out("rst_mid_stall_rel", 5'b11111, 3'b000, 2'd0);

    // Timeout after 15 unanswered cycles; sticky until reset.
    @(negedge Clock);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (14) @(negedge Clock);
    #1;
    chk_out("to_cycle14", 5'b00000, 3'b000, 2'd1);
    chk("to_cycle14.timeout", 16'(hz.MemTimeout), 16'd0);
    @(negedge Clock);
    #1;
    chk_out("to_cycle15", 5'b00000, 3'b000, 2'd2);
    chk("to_cycle15.timeout", 16'(hz.MemTimeout), 16'd1);
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge Clock);
    #1;
    chk_out("err_held", 5'b00000, 3'b000, 2'd2);
    chk("err_held.timeout", 16'(hz.MemTimeout), 16'd1);
    Reset = 1'b0;
    idle();
    @(negedge Clock);
    #1;
    chk_out("err_reset", 5'b00000, 3'b111, 2'd0);
    chk("err_reset.timeout", 16'(hz.MemTimeout), 16'd0);
    Reset = 1'b1;
    @(negedge Clock);
    #1;
    chk_out("err_reset_run", 5'b11111, 3'b000, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
